// File: rtl/neo_sequencer.sv
// rtl/neo_sequencer.sv - NEO frame sequencer: load samples, compute psi into shared memory, stream results
//
// Loads L=M/2 signed samples into memory words 0..L-1, computes
// psi[n] = x[n]^2 - x[n-1]*x[n+1] (x[-1]=x[L]=0) into words L..M-1,
// then streams the results out in order.
//
// Ports:
//   Clk, reset            clock; asynchronous active-high reset
//   start                 1-cycle pulse, begins a frame from IDLE
//   in_valid/in_data/in_ready     sample input handshake
//   mem_raddr/mem_rdata   memory read port (rdata valid one cycle after raddr)
//   mem_we/mem_waddr/mem_wdata    memory write port
//   out_valid/out_data/out_ready  result output handshake
//   busy, done, sat       status: not idle, frame drained pulse, sticky clip flag
module neo_sequencer #(
    parameter int N     = 16,
    parameter int M     = 32,
    parameter int SHIFT = N - 1
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [N-1:0]           in_data,
    output logic                   in_ready,
    output logic [$clog2(M)-1:0]   mem_raddr,
    input  logic [N-1:0]           mem_rdata,
    output logic                   mem_we,
    output logic [$clog2(M)-1:0]   mem_waddr,
    output logic [N-1:0]           mem_wdata,
    output logic                   out_valid,
    output logic [N-1:0]           out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   sat
);

    localparam int AW = $clog2(M);
    localparam int L  = M / 2;

    localparam logic [AW-1:0] LA   = AW'(L);
    localparam logic [AW-1:0] LAST = AW'(L - 1);
    localparam logic [AW-1:0] CEND = AW'(L + 1);
    localparam logic [AW-1:0] TWO  = AW'(2);

    localparam logic signed [2*N:0] MAXV = {{(N+2){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N:0] MINV = {{(N+2){1'b1}}, {(N-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state;
    logic [AW-1:0]       cnt;     // LOAD: sample index, CALC: cycle, DRAIN: accepted count
    logic [AW-1:0]       d_rd;    // DRAIN reads issued
    logic                pend;    // DRAIN read in flight, data arrives this cycle
    logic                ov;
    logic [N-1:0]        od;
    logic signed [N-1:0] prev;
    logic signed [N-1:0] cur;
    logic                sat_r;

    logic signed [N-1:0]   nxt;
    logic signed [2*N-1:0] sq;
    logic signed [2*N-1:0] pr;
    logic signed [2*N:0]   diff;
    logic signed [2*N:0]   shifted;
    logic [N-1:0]          clipped;
    logic                  clip;
    logic                  calc_wr;
    logic                  issue;
    logic                  accept;

    // In CALC cycle c the read data is x[c-1]; past the frame end it is the x[L]=0 boundary.
    assign nxt     = (cnt <= LA) ? mem_rdata : '0;
    assign sq      = (2*N)'(cur) * (2*N)'(cur);
    assign pr      = (2*N)'(prev) * (2*N)'(nxt);
    assign diff    = (2*N+1)'(sq) - (2*N+1)'(pr);
    assign shifted = diff >>> SHIFT;

    always_comb begin
        clip    = 1'b1;
        clipped = shifted[N-1:0];
        if (shifted > MAXV) begin
            clipped = MAXV[N-1:0];
        end else if (shifted < MINV) begin
            clipped = MINV[N-1:0];
        end else begin
            clip = 1'b0;
        end
    end

    assign calc_wr = (state == S_CALC) && (cnt >= TWO);

    // One read in flight at a time; a new read may launch while the held word is being taken.
    assign issue  = (state == S_DRAIN) && (d_rd < LA) && !pend && (!ov || out_ready);
    assign accept = (state == S_DRAIN) && ov && out_ready;

    assign in_ready  = (state == S_LOAD);
    assign mem_we    = ((state == S_LOAD) && in_valid) || calc_wr;
    assign mem_waddr = (state == S_LOAD) ? cnt : (calc_wr ? (LA + cnt - TWO) : '0);
    assign mem_wdata = (state == S_LOAD) ? in_data : (calc_wr ? clipped : '0);

    // Idle read addresses point at a half that is not being written, so read and write never collide.
    always_comb begin
        mem_raddr = '0;
        case (state)
            S_LOAD:  mem_raddr = LA;
            S_CALC:  mem_raddr = (cnt < LA) ? cnt : '0;
            S_DRAIN: mem_raddr = issue ? (LA + d_rd) : LA;
            default: mem_raddr = '0;
        endcase
    end

    assign out_valid = ov;
    assign out_data  = od;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign sat       = sat_r;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            d_rd  <= '0;
            pend  <= 1'b0;
            ov    <= 1'b0;
            od    <= '0;
            prev  <= '0;
            cur   <= '0;
            sat_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                        d_rd  <= '0;
                        pend  <= 1'b0;
                        ov    <= 1'b0;
                        prev  <= '0;
                        cur   <= '0;
                        sat_r <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (cnt == LAST) begin
                            state <= S_CALC;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt != '0) begin
                        prev <= cur;
                        cur  <= nxt;
                    end
                    if (calc_wr && clip) begin
                        sat_r <= 1'b1;
                    end
                    if (cnt == CEND) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                        d_rd  <= '0;
                        pend  <= 1'b0;
                        ov    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (accept) begin
                        ov <= 1'b0;
                        if (cnt == LAST) begin
                            state <= S_DONE;
                        end
                        cnt <= cnt + 1'b1;
                    end
                    if (pend) begin
                        ov <= 1'b1;
                        od <= mem_rdata;
                    end
                    pend <= issue;
                    if (issue) begin
                        d_rd <= d_rd + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
